// File: rtl/shift_pkg.sv
// shift_pkg: op codes, FSM state type and op helpers for the shift sequencer
package shift_pkg;
  localparam logic [2:0] OP_SHR  = 3'd0;
  localparam logic [2:0] OP_SHRA = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_ROR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  function automatic logic is_rotate(input logic [2:0] op);
    return op == OP_ROR || op == OP_ROL;
  endfunction
endpackage

// File: rtl/shift_stage.sv
// shift_stage: one log2 shift stage selected by index; shifts val by 2**stage when en
//   val in [WIDTH], op in [3], stage in [STAGES], en in; out out [WIDTH]
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]  val,
  input  logic [2:0]        op,
  input  logic [STAGES-1:0] stage,
  input  logic              en,
  output logic [WIDTH-1:0]  out
);
  logic [WIDTH-1:0] cand [STAGES];
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int K = 2 ** s;
    assign cand[s] = op == OP_SHR  ? {{K{1'b0}}, val[WIDTH-1:K]} :
                     op == OP_SHRA ? {{K{val[WIDTH-1]}}, val[WIDTH-1:K]} :
                     op == OP_SHL  ? {val[WIDTH-1-K:0], {K{1'b0}}} :
                     op == OP_ROR  ? {val[K-1:0], val[WIDTH-1:K]} :
                     op == OP_ROL  ? {val[WIDTH-1-K:0], val[WIDTH-1:WIDTH-K]} : val;
  end
  always_comb begin
    out = val;
    for (int i = 0; i < STAGES; i++)
      if (en && stage == STAGES'(i)) out = cand[i];
  end
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift/rotate controller, one log2 stage per clock
//   clk, rst_n (async low) in; start, op[3], data_in[W], amt[W], kill in
//   busy, done, err, result[W] out
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] amt,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);
  localparam int STAGES = $clog2(WIDTH);
  state_t            state;
  logic [WIDTH-1:0]  acc, stage_out, fast_val;
  logic [STAGES-1:0] stage, amt_reg;
  logic [2:0]        op_reg;
  logic              legal, rot, big, fast;
  assign legal = op <= OP_ROL;
  assign rot   = is_rotate(op);
  // amt >= WIDTH exactly when any bit above the stage bits is set (WIDTH is a power of two)
  assign big   = |amt[WIDTH-1:STAGES];
  assign fast  = !legal || amt == '0 || (rot && amt[STAGES-1:0] == '0) || (big && !rot);
  assign fast_val = (!legal || !big || rot) ? data_in :
                    op == OP_SHRA ? {WIDTH{data_in[WIDTH-1]}} : '0;
  assign busy = state != ST_IDLE;
  assign done = state == ST_DONE;
  // amt_reg shifts right each RUN cycle so its LSB is always the current stage's enable
  shift_stage #(.WIDTH(WIDTH), .STAGES(STAGES)) u_stage (
    .val(acc), .op(op_reg), .stage(stage), .en(amt_reg[0]), .out(stage_out)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      acc     <= '0;
      stage   <= '0;
      amt_reg <= '0;
      op_reg  <= '0;
      err     <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start && !kill) begin
          op_reg  <= op;
          amt_reg <= amt[STAGES-1:0];
          stage   <= '0;
          err     <= !legal;
          acc     <= fast ? fast_val : data_in;
          if (fast) result <= fast_val;
          state   <= fast ? ST_DONE : ST_RUN;
        end
        ST_RUN: if (kill) state <= ST_IDLE;
        else begin
          acc     <= stage_out;
          amt_reg <= {1'b0, amt_reg[STAGES-1:1]};
          stage   <= stage + 1'b1;
          if (stage == STAGES'(STAGES - 1)) begin
            result <= stage_out;
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
